// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, fetches an 8-word block from main memory,
// writes each returned word into the data array, then writes the tag once.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        mem_read_en,
  output logic [15:0] mem_addr,
  output logic [15:0] array_addr,
  output logic [15:0] array_data,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic        fsm_busy
);

  // state | meaning
  // IDLE  | waiting for a miss; all outputs low
  // FILL  | issuing 8 word reads and writing each returned word
  // TAG   | single-cycle tag write, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  localparam logic [3:0] WORDS = 4'd8;

  state_t      state;
  logic [15:0] base;
  logic [3:0]  issue_cnt;
  logic [3:0]  recv_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= 16'h0000;
      issue_cnt <= 4'd0;
      recv_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state     <= FILL;
            base      <= miss_address & 16'hFFF0;
            issue_cnt <= 4'd0;
            recv_cnt  <= 4'd0;
          end
        end
        FILL: begin
          if (issue_cnt != WORDS) issue_cnt <= issue_cnt + 4'd1;
          // Returns are counted independently of requests, so latency never matters.
          if (memory_data_valid && (recv_cnt != WORDS)) begin
            recv_cnt <= recv_cnt + 4'd1;
            if (recv_cnt == WORDS - 4'd1) state <= TAG;
          end
        end
        TAG: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_read_en      = 1'b0;
    mem_addr         = 16'h0000;
    array_addr       = 16'h0000;
    array_data       = 16'h0000;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fsm_busy         = 1'b0;
    case (state)
      FILL: begin
        fsm_busy   = 1'b1;
        array_addr = base;
        if (issue_cnt < WORDS) begin
          mem_read_en = 1'b1;
          mem_addr    = base + {11'd0, issue_cnt[2:0], 1'b0};
        end
        if (memory_data_valid && (recv_cnt < WORDS)) begin
          write_data_array = 1'b1;
          array_data       = memory_data;
          array_addr       = base + {11'd0, recv_cnt[2:0], 1'b0};
        end
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        array_addr      = base;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: each fill is modelled as a timeline of
// request cycles and a valid schedule, from which every cycle's outputs are predicted.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        mem_read_en;
  logic [15:0] mem_addr;
  logic [15:0] array_addr;
  logic [15:0] array_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic        fsm_busy;

  int checks = 0;
  int errors = 0;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .mem_read_en      (mem_read_en),
    .mem_addr         (mem_addr),
    .array_addr       (array_addr),
    .array_data       (array_data),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .fsm_busy         (fsm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string where);
    chk({where, ".busy"}, 16'(fsm_busy), 16'h0);
    chk({where, ".rd"}, 16'(mem_read_en), 16'h0);
    chk({where, ".mem_addr"}, mem_addr, 16'h0);
    chk({where, ".wr"}, 16'(write_data_array), 16'h0);
    chk({where, ".array_addr"}, array_addr, 16'h0);
    chk({where, ".array_data"}, array_data, 16'h0);
    chk({where, ".tag"}, 16'(write_tag_array), 16'h0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n             = 1'b1;
      miss_detected     = 1'b0;
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom_range(0, 1));
      memory_data       = 16'($urandom);
      #1 check_idle("idle");
    end
  endtask

  // mode 0: valid 4 cycles after each request; 1: same-cycle valid with 0x1111.. data;
  // 2: random gaps of 0..6 cycles between valids.
  task automatic run_fill(input logic [15:0] addr, input int mode, input bit abort, input bit hold);
    int          v[8];
    bit          is_v[64];
    int          vidx[64];
    int          last;
    bit          exp_rd;
    bit          exp_wr;
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 64; i++) begin
      is_v[i] = 1'b0;
      vidx[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       v[i] = 5 + i;
        1:       v[i] = 1 + i;
        default: v[i] = ((i == 0) ? 1 : v[i-1] + 1) + $urandom_range(0, 6);
      endcase
      is_v[v[i]] = 1'b1;
      vidx[v[i]] = i;
    end
    last = abort ? v[2] + 1 : v[7] + 1;

    @(negedge clk);
    rst_n             = 1'b1;
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'($urandom_range(0, 1));
    memory_data       = 16'($urandom);
    #1 check_idle("start");

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      miss_detected = hold ? 1'b1 : 1'($urandom_range(0, 1));
      miss_address  = 16'($urandom);
      if (abort && c == last) begin
        rst_n             = 1'b0;
        memory_data_valid = 1'b0;
      end else if (c == last) begin
        memory_data_valid = 1'($urandom_range(0, 1));
      end else begin
        memory_data_valid = is_v[c];
      end
      memory_data = (mode == 1) ? 16'(16'h1111 * (vidx[c] + 1)) : 16'($urandom);
      #1;
      chk("busy", 16'(fsm_busy), 16'h1);
      if (abort || c < last) begin
        exp_rd = (c <= 8);
        exp_wr = memory_data_valid;
        chk("rd", 16'(mem_read_en), 16'(exp_rd));
        chk("mem_addr", mem_addr, exp_rd ? 16'(base + 16'(2 * (c - 1))) : 16'h0);
        chk("wr", 16'(write_data_array), 16'(exp_wr));
        chk("array_addr", array_addr, exp_wr ? 16'(base + 16'(2 * vidx[c])) : base);
        if (exp_wr) chk("array_data", array_data, memory_data);
        chk("tag_in_fill", 16'(write_tag_array), 16'h0);
      end else begin
        chk("tag", 16'(write_tag_array), 16'h1);
        chk("tag.wr", 16'(write_data_array), 16'h0);
        chk("tag.rd", 16'(mem_read_en), 16'h0);
        chk("tag.array_addr", array_addr, base);
      end
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data       = 16'h0;
    memory_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_idle("reset");

    run_fill(16'h3A56, 0, 1'b0, 1'b0);
    run_fill(16'h1234, 1, 1'b0, 1'b0);
    idle_cycles(5);
    run_fill(16'($urandom), 2, 1'b0, 1'b0);
    run_fill(16'($urandom), 2, 1'b1, 1'b0);
    run_fill(16'h0008, 2, 1'b0, 1'b0);
    run_fill(16'($urandom), 2, 1'b0, 1'b1);
    run_fill(16'($urandom), 0, 1'b0, 1'b1);
    run_fill(16'hFFFE, 0, 1'b0, 1'b0);
    idle_cycles(3);
    for (int n = 0; n < 12; n++) begin
      run_fill(16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
